// File: rtl/ieee754_arb_pkg.sv
// Shared types and helpers for the single-precision multiplier arbiter.
package ieee754_arb_pkg;

  localparam int FP_WIDTH = 32;
  localparam int MAX_REQ  = 16;
  localparam int TAG_ID_W = $clog2(MAX_REQ);

  // One slot of the tag pipeline that shadows the multiplier latency.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // Requester index to one-hot response vector.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [TAG_ID_W-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

endpackage

// File: rtl/ieee754_mult_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_idx;

  // Walk requesters from rr_ptr+1 around to rr_ptr; the first active one wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant_idx    = w_idx;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ieee754_mult_arbiter.sv
// Shares one fixed-latency FP32 multiplier between NUM_REQ requesters.
// Operands are registered onto the multiplier bus, a tag pipeline tracks
// which requester owns each in-flight product, and results come back as
// one-cycle pulses on a shared data bus, in issue order.
module ieee754_mult_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic [31:0]           mult_a,
  output logic [31:0]           mult_b,
  input  logic [31:0]           mult_y,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  issue_count
);

  import ieee754_arb_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]    w_grant_idx;
  logic                w_any;
  logic                w_accept;
  logic [FP_WIDTH-1:0] w_sel_a;
  logic [FP_WIDTH-1:0] w_sel_b;
  logic [NUM_REQ-1:0]  w_rsp_oh;
  logic                w_busy;

  logic [IDX_W-1:0]     r_rr_ptr;
  logic [FP_WIDTH-1:0]  r_mult_a;
  logic [FP_WIDTH-1:0]  r_mult_b;
  tag_t                 r_tag [0:MULT_LATENCY];
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [FP_WIDTH-1:0]  r_rsp_data;
  logic [CNT_WIDTH-1:0] r_issue_count;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req       (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // Grants are suppressed while reset is held so nothing is accepted.
  assign req_ready = {NUM_REQ{resetn}} & w_grant;
  assign w_accept  = resetn & w_any;
  assign w_sel_a   = req_a[FP_WIDTH*w_grant_idx +: FP_WIDTH];
  assign w_sel_b   = req_b[FP_WIDTH*w_grant_idx +: FP_WIDTH];

  // ---- issue stage: operand registers, pointer, counter ----

  // Capture the winner's operands; hold the bus when nothing is accepted.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_mult_a <= '0;
      r_mult_b <= '0;
    end else if (w_accept) begin
      r_mult_a <= w_sel_a;
      r_mult_b <= w_sel_b;
    end
  end

  // Remember the last winner so the next search starts just past it.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (w_accept) begin
      r_rr_ptr <= w_grant_idx;
    end
  end

  // Count accepted operations; wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_issue_count <= '0;
    end else if (w_accept) begin
      r_issue_count <= r_issue_count + 1'b1;
    end
  end

  // ---- tag pipeline: MULT_LATENCY+1 stages, aligned with mult_y ----

  // Shift the owner tag every cycle; reset drops all in-flight work.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int k = 0; k <= MULT_LATENCY; k++) begin
        r_tag[k].valid <= 1'b0;
      end
    end else begin
      r_tag[0] <= {w_accept, TAG_ID_W'(w_grant_idx)};
      for (int k = 1; k <= MULT_LATENCY; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // Busy while any pipeline slot holds a live operation.
  always_comb begin
    w_busy = 1'b0;
    for (int k = 0; k <= MULT_LATENCY; k++) begin
      w_busy = w_busy | r_tag[k].valid;
    end
  end

  // ---- response stage: route mult_y to the owning requester ----

  assign w_rsp_oh = NUM_REQ'(onehot(r_tag[MULT_LATENCY].id));

  // Pulse the owner's rsp_valid for one cycle; data holds between results.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= r_tag[MULT_LATENCY].valid ? w_rsp_oh : '0;
      if (r_tag[MULT_LATENCY].valid) begin
        r_rsp_data <= mult_y;
      end
    end
  end

  assign mult_a      = r_mult_a;
  assign mult_b      = r_mult_b;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign busy        = w_busy;
  assign issue_count = r_issue_count;

endmodule

// File: tb/tb_ieee754_mult_arbiter.sv
// Directed bench for ieee754_mult_arbiter with a 2-cycle FP32 multiplier
// stand-in. Inputs change on the falling edge; outputs are checked there too.
module tb_ieee754_mult_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 2;
  localparam int CW      = 4;

  logic            clock;
  logic            resetn;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [127:0]    req_a;
  logic [127:0]    req_b;
  logic [3:0]      rsp_valid;
  logic [31:0]     rsp_data;
  logic [31:0]     mult_a;
  logic [31:0]     mult_b;
  logic [31:0]     mult_y;
  logic [31:0]     m_stage1;
  logic            busy;
  logic [CW-1:0]   issue_count;

  int checks = 0;
  int errors = 0;

  ieee754_mult_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .MULT_LATENCY (LAT),
    .CNT_WIDTH    (CW)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_y      (mult_y),
    .busy        (busy),
    .issue_count (issue_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Simple FP32 multiply for normal, exactly representable products; zero in -> zero out.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return 32'h0;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  // Two-register multiplier model: operands registered in the DUT, product two edges later.
  always @(posedge clock) begin
    m_stage1 <= fp_mul(mult_a, mult_b);
    mult_y   <= m_stage1;
  end

  task automatic do_reset();
    @(negedge clock);
    resetn    = 1'b0;
    req_valid = 4'b0000;
    @(negedge clock);
    resetn    = 1'b1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (issue_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", issue_count); end
    checks++; if (mult_a !== 32'h0 || mult_b !== 32'h0) begin errors++; $display("FAIL reset_mult_ab: got %h/%h want 0/0", mult_a, mult_b); end
    @(negedge clock);
    resetn    = 1'b1;
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    logic [3:0] exp_rsp;
    logic       exp_busy;
    @(negedge clock);
    req_a[31:0] = 32'h40000000;
    req_b[31:0] = 32'h40400000;
    req_valid   = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (c == 1) begin
        checks++; if (mult_a !== 32'h40000000 || mult_b !== 32'h40400000) begin errors++; $display("FAIL single_operands: got %h/%h want 40000000/40400000", mult_a, mult_b); end
        checks++; if (issue_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d want 1", issue_count); end
        req_valid = 4'b0000;
      end
      exp_rsp  = (c == 4) ? 4'b0001 : 4'b0000;
      exp_busy = (c <= 3);
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL single_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL single_busy c%0d: got %b want %b", c, busy, exp_busy); end
      if (c == 4) begin
        checks++; if (rsp_data !== 32'h40C00000) begin errors++; $display("FAIL single_rsp_data: got %h want 40c00000", rsp_data); end
      end
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_rsp;
    logic [3:0] exp_rdy;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'h3FC00000;
      req_b[32*i +: 32] = 32'h40000000;
    end
    for (int n = 0; n <= 9; n++) begin
      @(negedge clock);
      exp_rsp = (n >= 4 && n <= 8) ? (4'b0001 << ((n - 4) % 4)) : 4'b0000;
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL contention_rsp n%0d: got %b want %b", n, rsp_valid, exp_rsp); end
      if (exp_rsp != 4'b0000) begin
        checks++; if (rsp_data !== 32'h40400000) begin errors++; $display("FAIL contention_data n%0d: got %h want 40400000", n, rsp_data); end
      end
      if (n < 5) begin
        req_valid = 4'hF;
        #1;
        exp_rdy = 4'b0001 << (n % 4);
        checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL contention_grant n%0d: got %b want %b", n, req_ready, exp_rdy); end
      end else begin
        req_valid = 4'b0000;
      end
    end
    checks++; if (issue_count !== 4'd5) begin errors++; $display("FAIL contention_count: got %0d want 5", issue_count); end
  endtask

  task automatic test_fairness();
    logic [3:0] vtab [4];
    logic [3:0] rtab [4];
    logic [3:0] exp_rsp;
    vtab = '{4'b0001, 4'b0010, 4'b0011, 4'b0011};
    rtab = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    do_reset();
    for (int n = 0; n <= 8; n++) begin
      @(negedge clock);
      exp_rsp = (n >= 4 && n <= 7) ? rtab[n - 4] : 4'b0000;
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL fairness_rsp n%0d: got %b want %b", n, rsp_valid, exp_rsp); end
      if (n < 4) begin
        req_valid = vtab[n];
        #1;
        checks++; if (req_ready !== rtab[n]) begin errors++; $display("FAIL fairness_grant n%0d: got %b want %b", n, req_ready, rtab[n]); end
      end else begin
        req_valid = 4'b0000;
      end
    end
  endtask

  task automatic test_sign_zero();
    logic [3:0] exp_rsp;
    req_a[64 +: 32] = 32'hC0000000;
    req_b[64 +: 32] = 32'h40400000;
    req_a[96 +: 32] = 32'h00000000;
    req_b[96 +: 32] = 32'h41200000;
    for (int n = 0; n <= 6; n++) begin
      @(negedge clock);
      exp_rsp = (n == 4) ? 4'b0100 : ((n == 5) ? 4'b1000 : 4'b0000);
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL signzero_rsp n%0d: got %b want %b", n, rsp_valid, exp_rsp); end
      if (n == 4) begin
        checks++; if (rsp_data !== 32'hC0C00000) begin errors++; $display("FAIL sign_data: got %h want c0c00000", rsp_data); end
      end
      if (n == 5) begin
        checks++; if (rsp_data !== 32'h00000000) begin errors++; $display("FAIL zero_data: got %h want 00000000", rsp_data); end
      end
      if (n == 0) begin
        req_valid = 4'b1100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL signzero_grant0: got %b want 0100", req_ready); end
      end else if (n == 1) begin
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL signzero_grant1: got %b want 1000", req_ready); end
      end else begin
        req_valid = 4'b0000;
      end
    end
    checks++; if (issue_count !== 4'd6) begin errors++; $display("FAIL signzero_count: got %0d want 6", issue_count); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int n = 0; n <= 9; n++) begin
      @(negedge clock);
      if (n >= 3) begin
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL midreset_rsp n%0d: got %b want 0000", n, rsp_valid); end
      end
      if (n == 0) begin
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midreset_grant0: got %b want 0001", req_ready); end
      end else if (n == 1) begin
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL midreset_grant1: got %b want 0010", req_ready); end
      end else if (n == 2) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
        req_valid = 4'b0000;
        resetn    = 1'b0;
      end else if (n == 3) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        checks++; if (issue_count !== 4'd0) begin errors++; $display("FAIL midreset_count: got %0d want 0", issue_count); end
        checks++; if (mult_a !== 32'h0 || mult_b !== 32'h0) begin errors++; $display("FAIL midreset_mult_ab: got %h/%h want 0/0", mult_a, mult_b); end
        resetn = 1'b1;
      end else if (n == 9) begin
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midreset_first_grant: got %b want 0001", req_ready); end
        req_valid = 4'b0000;
      end
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [31:0] exp_data;
    do_reset();
    req_b[31:0] = 32'h40400000;
    for (int n = 0; n <= 21; n++) begin
      @(negedge clock);
      if (n >= 4 && n <= 20) begin
        exp_data = 32'h40400000 + ((n - 4) << 23);
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL b2b_rsp n%0d: got %b want 0001", n, rsp_valid); end
        checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL b2b_data n%0d: got %h want %h", n, rsp_data, exp_data); end
      end else begin
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL b2b_idle n%0d: got %b want 0000", n, rsp_valid); end
      end
      if (n == 17) begin
        checks++; if (issue_count !== 4'd1) begin errors++; $display("FAIL wrap_count: got %0d want 1", issue_count); end
      end
      if (n < 17) begin
        req_a[31:0] = 32'h3F800000 + (n << 23);
        req_valid   = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_grant n%0d: got %b want 0001", n, req_ready); end
      end else begin
        req_valid = 4'b0000;
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_sign_zero();
    test_reset_midflight();
    test_back_to_back_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
